// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared types, standard mode constants and helper functions
// for the raster timing generator.
//   phase_t      four-phase axis state (ACTIVE, FRONT, SYNC, BACK)
//   VGA640_*     640x480@60 timing (25 MHz pixel clock, CLK_DIV 4 from 100 MHz)
//   SVGA800_*    800x600@60 timing (40 MHz pixel clock, CLK_DIV 2 from 80 MHz)
//   total_len    sum of the four segment lengths of one axis
//   req_width    number of bits needed to hold a given maximum value
package vga_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } phase_t;

    localparam int unsigned VGA640_CLK_DIV = 4;
    localparam int unsigned VGA640_HD      = 640;
    localparam int unsigned VGA640_HF      = 16;
    localparam int unsigned VGA640_HS      = 96;
    localparam int unsigned VGA640_HB      = 48;
    localparam int unsigned VGA640_VD      = 480;
    localparam int unsigned VGA640_VF      = 10;
    localparam int unsigned VGA640_VS      = 2;
    localparam int unsigned VGA640_VB      = 33;
    localparam bit          VGA640_HS_POL  = 1'b0;
    localparam bit          VGA640_VS_POL  = 1'b0;

    localparam int unsigned SVGA800_CLK_DIV = 2;
    localparam int unsigned SVGA800_HD      = 800;
    localparam int unsigned SVGA800_HF      = 40;
    localparam int unsigned SVGA800_HS      = 128;
    localparam int unsigned SVGA800_HB      = 88;
    localparam int unsigned SVGA800_VD      = 600;
    localparam int unsigned SVGA800_VF      = 1;
    localparam int unsigned SVGA800_VS      = 4;
    localparam int unsigned SVGA800_VB      = 23;
    localparam bit          SVGA800_HS_POL  = 1'b1;
    localparam bit          SVGA800_VS_POL  = 1'b1;

    function automatic int unsigned total_len(input int unsigned d, input int unsigned f,
                                              input int unsigned s, input int unsigned b);
        return d + f + s + b;
    endfunction

    function automatic int unsigned req_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((max_val >> w) != 0) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: run-enable and raster timing outputs of vga_timing_gen.
//   master: generator side (drives timing, receives en)
//   slave : consumer side (drives en, receives timing)
//   en, p_tick, x[X_W], y[Y_W], video_on, hsync, vsync, line_start, frame_start,
//   frame_cnt[FC_W] only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
    parameter int unsigned X_W  = 10,
    parameter int unsigned Y_W  = 10,
    parameter int unsigned FC_W = 16
) ();

    logic           en;
    logic           p_tick;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           video_on;
    logic           hsync;
    logic           vsync;
    logic           line_start;
    logic           frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FC_W-1:0] frame_cnt;
`endif

    if (FC_W == 0) begin : g_bad_fc_w
        $error("vga_timing_gen_if: FC_W must be >= 1");
    end

    modport master (
        input  en,
        output p_tick, x, y, video_on, hsync, vsync, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        output en,
        input  p_tick, x, y, video_on, hsync, vsync, line_start, frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
        , input frame_cnt
`endif
    );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical). A position
// counter 0..LEN-1 with a four-phase state machine ACTIVE->FRONT->SYNC->BACK.
//   clk, rst : clock, asynchronous active-high reset
//   adv      : advance one position this clock
//   pos[W]   : current position
//   phase    : current phase
//   wrap     : combinational, high when this advance returns pos to 0
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned LEN_D = 640,
    parameter int unsigned LEN_F = 16,
    parameter int unsigned LEN_S = 96,
    parameter int unsigned LEN_B = 48,
    parameter int unsigned W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    output logic [W-1:0] pos,
    output phase_t       phase,
    output logic         wrap
);

    localparam int unsigned LEN = total_len(LEN_D, LEN_F, LEN_S, LEN_B);

    // Last position of each segment; the phase changes as pos steps past it.
    localparam logic [W-1:0] LAST  = W'(LEN - 1);
    localparam logic [W-1:0] END_D = W'(LEN_D - 1);
    localparam logic [W-1:0] END_F = W'(LEN_D + LEN_F - 1);
    localparam logic [W-1:0] END_S = W'(LEN_D + LEN_F + LEN_S - 1);

    logic [W-1:0] pos_q;
    phase_t       phase_q;
    logic         at_end;

    assign at_end = (pos_q == LAST);
    assign wrap   = adv & at_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q   <= '0;
            phase_q <= ACTIVE;
        end else if (adv) begin
            if (at_end) begin
                pos_q   <= '0;
                phase_q <= ACTIVE;
            end else begin
                pos_q <= pos_q + 1'b1;
                case (phase_q)
                    ACTIVE: if (pos_q == END_D) phase_q <= FRONT;
                    FRONT:  if (pos_q == END_F) phase_q <= SYNC;
                    SYNC:   if (pos_q == END_S) phase_q <= BACK;
                    default: phase_q <= phase_q;
                endcase
            end
        end
    end

    assign pos   = pos_q;
    assign phase = phase_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator. Divides clk_100MHz by
// CLK_DIV to a pixel tick and produces aligned x/y, video_on, hsync/vsync and
// line/frame start strobes. Defaults give 640x480@60.
//   clk_100MHz : system clock
//   reset      : asynchronous, active-high
//   bus        : vga_timing_gen_if.master (en in; timing outputs out)
// Optional: define VGA_TIMING_FRAME_CNT_EN to add bus.frame_cnt, a frame
// counter that steps with every frame_start and wraps at 2^FC_W.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = VGA640_CLK_DIV,
    parameter int unsigned HD      = VGA640_HD,
    parameter int unsigned HF      = VGA640_HF,
    parameter int unsigned HS      = VGA640_HS,
    parameter int unsigned HB      = VGA640_HB,
    parameter int unsigned VD      = VGA640_VD,
    parameter int unsigned VF      = VGA640_VF,
    parameter int unsigned VS      = VGA640_VS,
    parameter int unsigned VB      = VGA640_VB,
    parameter bit          HS_POL  = VGA640_HS_POL,
    parameter bit          VS_POL  = VGA640_VS_POL,
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 10,
    parameter int unsigned FC_W    = 16
) (
    input logic             clk_100MHz,
    input logic             reset,
    vga_timing_gen_if.master bus
);

    localparam int unsigned HT    = total_len(HD, HF, HS, HB);
    localparam int unsigned VT    = total_len(VD, VF, VS, VB);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (HD == 0 || HF == 0 || HS == 0 || HB == 0) begin : g_bad_h
        $error("vga_timing_gen: horizontal segment lengths must be >= 1");
    end
    if (VD == 0 || VF == 0 || VS == 0 || VB == 0) begin : g_bad_v
        $error("vga_timing_gen: vertical segment lengths must be >= 1");
    end
    if (X_W < req_width(HT - 1)) begin : g_bad_x_w
        $error("vga_timing_gen: X_W too small for HD+HF+HS+HB-1");
    end
    if (Y_W < req_width(VT - 1)) begin : g_bad_y_w
        $error("vga_timing_gen: Y_W too small for VD+VF+VS+VB-1");
    end
    if (FC_W == 0) begin : g_bad_fc_w
        $error("vga_timing_gen: FC_W must be >= 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             p_tick_q, p_tick_d;

    // Wrap flags registered alongside the counter update, so the strobes
    // land one clock later together with the x/y they describe.
    logic             line_pend_q, frame_pend_q;

    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic             video_on_q, hsync_q, vsync_q;
    logic             line_start_q, frame_start_q;

    logic             h_adv, h_wrap, v_wrap;
    logic [X_W-1:0]   h_pos;
    logic [Y_W-1:0]   v_pos;
    phase_t           h_phase, v_phase;

    always_comb begin
        p_tick_d = (div_q == DIV_W'(CLK_DIV - 1));
        div_d    = p_tick_d ? '0 : div_q + 1'b1;
    end

    // The counters consume the registered tick, so they are frozen with en.
    assign h_adv = bus.en & p_tick_q;

    vga_axis_counter #(
        .LEN_D (HD),
        .LEN_F (HF),
        .LEN_S (HS),
        .LEN_B (HB),
        .W     (X_W)
    ) u_h (
        .clk   (clk_100MHz),
        .rst   (reset),
        .adv   (h_adv),
        .pos   (h_pos),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .LEN_D (VD),
        .LEN_F (VF),
        .LEN_S (VS),
        .LEN_B (VB),
        .W     (Y_W)
    ) u_v (
        .clk   (clk_100MHz),
        .rst   (reset),
        .adv   (h_wrap),
        .pos   (v_pos),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FC_W-1:0] frame_cnt_q;
`endif

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            p_tick_q      <= 1'b0;
            line_pend_q   <= 1'b0;
            frame_pend_q  <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            video_on_q    <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
            frame_cnt_q   <= '0;
`endif
        end else if (bus.en) begin
            div_q         <= div_d;
            p_tick_q      <= p_tick_d;
            line_pend_q   <= h_wrap;
            frame_pend_q  <= v_wrap;
            x_q           <= h_pos;
            y_q           <= v_pos;
            video_on_q    <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
            hsync_q       <= (h_phase == SYNC) ? HS_POL : ~HS_POL;
            vsync_q       <= (v_phase == SYNC) ? VS_POL : ~VS_POL;
            line_start_q  <= line_pend_q;
            frame_start_q <= frame_pend_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (frame_pend_q) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
`endif
        end
    end

    assign bus.p_tick      = p_tick_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.video_on    = video_on_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
`ifdef VGA_TIMING_FRAME_CNT_EN
    assign bus.frame_cnt   = frame_cnt_q;
`endif

endmodule
